// File: rtl/move_pkg.sv
// Shared types for the move controller: FSM encoding, winner codes and
// board-size derivations.
package move_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_COMMIT = 3'd2,
        S_EVAL   = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic int cells_f(input int n);
        return n * n;
    endfunction

    function automatic int pos_w_f(input int n);
        return $clog2(n * n + 1);
    endfunction

endpackage

// File: rtl/move_controller_cell_decoder.sv
// 1-based cell index to one-hot decoder; all-zero when disabled or when the
// index is 0 or beyond the board.
module cell_decoder #(
    parameter int CELLS = 9,
    parameter int POS_W = 4
) (
    input  logic             en_i,
    input  logic [POS_W-1:0] pos_i,
    output logic [CELLS-1:0] onehot_o
);

    // Bit k fires for index k+1, so out-of-range indices decode to nothing
    always_comb begin
        onehot_o = {CELLS{1'b0}};
        for (int k = 0; k < CELLS; k++) begin
            onehot_o[k] = en_i && (pos_i == POS_W'(k + 1));
        end
    end

endmodule

// File: rtl/move_controller.sv
// Turn-based board game move controller (BOARD_N x BOARD_N).
// Define WIN_DETECT_EN to enable row/column/diagonal win detection.
module move_controller
    import move_pkg::*;
#(
    parameter  int BOARD_N = 3,
    localparam int CELLS   = cells_f(BOARD_N),
    localparam int POS_W   = pos_w_f(BOARD_N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             new_game,
    input  logic             play_valid,
    input  logic [POS_W-1:0] pos,
    output logic             ready,
    output logic [CELLS-1:0] board_p1,
    output logic [CELLS-1:0] board_p2,
    output logic             turn,
    output logic             move_done,
    output logic             illegal,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic [POS_W-1:0] move_count
);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CELLS-1:0] board_p1_q, board_p1_d;
    logic [CELLS-1:0] board_p2_q, board_p2_d;
    logic             turn_q, turn_d;
    logic             move_done_q, move_done_d;
    logic             illegal_q, illegal_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q, winner_d;
    logic [POS_W-1:0] move_count_q, move_count_d;
    logic             ready_q, ready_d;

    logic [CELLS-1:0] dec_s;
    logic             dec_en_s;
    logic             bad_move_s;
    logic             win_s;
    logic             full_s;

    assign dec_en_s = (state_q == S_CHECK) || (state_q == S_COMMIT);

    cell_decoder #(
        .CELLS (CELLS),
        .POS_W (POS_W)
    ) u_cell_decoder (
        .en_i     (dec_en_s),
        .pos_i    (pos_q),
        .onehot_o (dec_s)
    );

    // An empty decode means pos was 0 or off the board
    assign bad_move_s = (dec_s == {CELLS{1'b0}}) ||
                        ((dec_s & (board_p1_q | board_p2_q)) != {CELLS{1'b0}});
    assign full_s     = (move_count_q == POS_W'(CELLS));

`ifdef WIN_DETECT_EN
    function automatic logic line_win(input logic [CELLS-1:0] b);
        logic hit, row, col, diag, anti;
        hit  = 1'b0;
        diag = 1'b1;
        anti = 1'b1;
        for (int i = 0; i < BOARD_N; i++) begin
            row = 1'b1;
            col = 1'b1;
            for (int j = 0; j < BOARD_N; j++) begin
                row = row & b[i*BOARD_N + j];
                col = col & b[j*BOARD_N + i];
            end
            hit  = hit | row | col;
            diag = diag & b[i*BOARD_N + i];
            anti = anti & b[i*BOARD_N + (BOARD_N - 1 - i)];
        end
        return hit | diag | anti;
    endfunction

    // Only the mover's board can have just completed a line
    assign win_s = line_win(turn_q ? board_p2_q : board_p1_q);
`else
    assign win_s = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pos_q        <= {POS_W{1'b0}};
            board_p1_q   <= {CELLS{1'b0}};
            board_p2_q   <= {CELLS{1'b0}};
            turn_q       <= 1'b0;
            move_done_q  <= 1'b0;
            illegal_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= WIN_NONE;
            move_count_q <= {POS_W{1'b0}};
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            board_p1_q   <= board_p1_d;
            board_p2_q   <= board_p2_d;
            turn_q       <= turn_d;
            move_done_q  <= move_done_d;
            illegal_q    <= illegal_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            move_count_q <= move_count_d;
            ready_q      <= ready_d;
        end
    end

    // Next-state and next-output logic; new_game overrides everything
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        board_p1_d   = board_p1_q;
        board_p2_d   = board_p2_q;
        turn_d       = turn_q;
        move_done_d  = 1'b0;
        illegal_d    = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        move_count_d = move_count_q;

        if (new_game) begin
            state_d      = S_IDLE;
            board_p1_d   = {CELLS{1'b0}};
            board_p2_d   = {CELLS{1'b0}};
            turn_d       = 1'b0;
            game_over_d  = 1'b0;
            winner_d     = WIN_NONE;
            move_count_d = {POS_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play_valid) begin
                        pos_d   = pos;
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (bad_move_s) begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (turn_q) begin
                        board_p2_d = board_p2_q | dec_s;
                    end else begin
                        board_p1_d = board_p1_q | dec_s;
                    end
                    move_count_d = move_count_q + POS_W'(1);
                    state_d      = S_EVAL;
                end
                S_EVAL: begin
                    move_done_d = 1'b1;
                    if (win_s || full_s) begin
                        game_over_d = 1'b1;
                        winner_d    = win_s ? (turn_q ? WIN_P2 : WIN_P1) : WIN_NONE;
                        state_d     = S_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_IDLE;
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        ready_d = (state_d == S_IDLE);
    end

    assign ready      = ready_q;
    assign board_p1   = board_p1_q;
    assign board_p2   = board_p2_q;
    assign turn       = turn_q;
    assign move_done  = move_done_q;
    assign illegal    = illegal_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign move_count = move_count_q;

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: 3x3 and 4x4 instances, directed moves.
module tb_move_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ng3, pv3, rdy3, t3, md3, il3, go3;
    logic [3:0]  pos3, c3;
    logic [8:0]  b1_3, b2_3;
    logic [1:0]  w3;
    logic        ng4, pv4, rdy4, t4, md4, il4, go4;
    logic [4:0]  pos4, c4;
    logic [15:0] b1_4, b2_4;
    logic [1:0]  w4;

    move_controller #(.BOARD_N(3)) dut3 (
        .clock(clk), .reset(rst), .new_game(ng3), .play_valid(pv3), .pos(pos3),
        .ready(rdy3), .board_p1(b1_3), .board_p2(b2_3), .turn(t3),
        .move_done(md3), .illegal(il3), .game_over(go3), .winner(w3), .move_count(c3)
    );

    move_controller #(.BOARD_N(4)) dut4 (
        .clock(clk), .reset(rst), .new_game(ng4), .play_valid(pv4), .pos(pos4),
        .ready(rdy4), .board_p1(b1_4), .board_p2(b2_4), .turn(t4),
        .move_done(md4), .illegal(il4), .game_over(go4), .winner(w4), .move_count(c4)
    );

    typedef struct packed {
        logic        ill;
        logic [15:0] b1;
        logic [15:0] b2;
        logic        turn;
        logic [4:0]  cnt;
        logic        go;
        logic [1:0]  win;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    int vectors = 0;
    int miscompares = 0;

    logic [15:0] em_b1 [2];
    logic [15:0] em_b2 [2];
    logic        em_t  [2];
    logic [4:0]  em_c  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic mreset(input int i);
        em_b1[i] = 16'h0000;
        em_b2[i] = 16'h0000;
        em_t[i]  = 1'b0;
        em_c[i]  = 5'd0;
    endtask

    task automatic sb_check(input int d, input exp_t a, input bit both);
        exp_t e;
        bit   have;
        have = (d == 3) ? (q3.size() != 0) : (q4.size() != 0);
        vectors++;
        if (both || !have) begin
            miscompares++;
            $display("FAIL sb%0d_pulse act=%h exp=one queued pulse (overlap=%0b queued=%0b)", d, a, both, have);
        end else begin
            if (d == 3) e = q3.pop_front();
            else        e = q4.pop_front();
            if (a !== e) begin
                miscompares++;
                $display("FAIL sb%0d_move act=%h exp=%h", d, a, e);
            end
        end
    endtask

    // Monitors: every pulse must match the oldest queued expectation
    always @(negedge clk) begin : mon3
        exp_t a;
        if (!rst && (md3 || il3)) begin
            a = '0;
            a.ill = il3; a.b1 = 16'(b1_3); a.b2 = 16'(b2_3); a.turn = t3;
            a.cnt = 5'(c3); a.go = go3; a.win = w3;
            sb_check(3, a, md3 && il3);
        end
    end

    always @(negedge clk) begin : mon4
        exp_t a;
        if (!rst && (md4 || il4)) begin
            a = '0;
            a.ill = il4; a.b1 = b1_4; a.b2 = b2_4; a.turn = t4;
            a.cnt = c4; a.go = go4; a.win = w4;
            sb_check(4, a, md4 && il4);
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (!(d == 3 ? rdy3 : rdy4) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("ready_wait_dut%0d", d), 32'(n >= 40), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q3.size() != 0 || q4.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", 32'(n >= 60), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic ngame(input int d);
        @(negedge clk);
        if (d == 3) ng3 = 1'b1; else ng4 = 1'b1;
        @(posedge clk); #1;
        ng3 = 1'b0; ng4 = 1'b0;
        mreset(d == 3 ? 0 : 1);
    endtask

    // Issue one move and queue the response it must produce
    task automatic play(input int d, input int p, input bit legal, input bit fin, input logic [1:0] w);
        exp_t e;
        int   i;
        i = (d == 3) ? 0 : 1;
        wait_ready(d);
        @(negedge clk);
        if (d == 3) begin pv3 = 1'b1; pos3 = 4'(p); end
        else        begin pv4 = 1'b1; pos4 = 5'(p); end
        @(posedge clk); #1;
        pv3 = 1'b0; pv4 = 1'b0;
        pos3 = 4'($urandom); pos4 = 5'($urandom);
        if (legal) begin
            if (!em_t[i]) em_b1[i][p-1] = 1'b1;
            else          em_b2[i][p-1] = 1'b1;
            em_c[i] = em_c[i] + 5'd1;
            if (!fin) em_t[i] = ~em_t[i];
        end
        e = '0;
        e.ill = !legal; e.b1 = em_b1[i]; e.b2 = em_b2[i]; e.turn = em_t[i];
        e.cnt = em_c[i]; e.go = fin; e.win = fin ? w : 2'b00;
        if (d == 3) q3.push_back(e);
        else        q4.push_back(e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ng3 = 1'b0; pv3 = 1'b0; pos3 = 4'd0;
        ng4 = 1'b0; pv4 = 1'b0; pos4 = 5'd0;
        mreset(0); mreset(1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(rdy3), 32'd1);
        chk("rst_boards", {b1_3, b2_3}, 32'd0);
        chk("rst_misc", {t3, md3, il3, go3, w3, c3}, 32'd0);
        chk("rst_dut4", {b1_4, b2_4}, 32'd0);

        // p1 plays 5, with cycle-exact latency
        play(3, 5, 1'b1, 1'b0, 2'b00);
        @(posedge clk); #1;
        chk("lat_c2_board", 32'(b1_3), 32'h000);
        @(posedge clk); #1;
        chk("lat_c3_board", 32'(b1_3), 32'h010);
        chk("lat_c3_done", 32'(md3), 32'd0);
        @(posedge clk); #1;
        chk("lat_c4_done_turn_ready", {md3, t3, rdy3}, 32'b111);

        // Illegal: occupied, zero, off-board
        play(3, 5, 1'b0, 1'b0, 2'b00);
        @(posedge clk); #1;
        chk("lat_ill_c2", 32'(il3), 32'd1);
        play(3, 0, 1'b0, 1'b0, 2'b00);
        play(3, 10, 1'b0, 1'b0, 2'b00);
        drain();
        chk("ill_state", {b1_3, b2_3, t3, c3}, {9'h010, 9'h000, 1'b1, 4'd1});

        // Row win for p1
        ngame(3);
        play(3, 1, 1'b1, 1'b0, 2'b00);
        play(3, 4, 1'b1, 1'b0, 2'b00);
        play(3, 2, 1'b1, 1'b0, 2'b00);
        play(3, 5, 1'b1, 1'b0, 2'b00);
`ifdef WIN_DETECT_EN
        play(3, 3, 1'b1, 1'b1, 2'b01);
        drain();
        chk("win_over", {w3, go3, rdy3}, {2'b01, 1'b1, 1'b0});
        @(negedge clk);
        pv3 = 1'b1; pos3 = 4'd6;
        repeat (5) @(posedge clk);
        #1 pv3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("over_ignores", {b1_3, b2_3, c3, rdy3}, {9'h007, 9'h018, 4'd5, 1'b0});
`else
        play(3, 3, 1'b1, 1'b0, 2'b00);
        drain();
        chk("nowin_continue", {w3, go3, rdy3, t3}, {2'b00, 1'b0, 1'b1, 1'b1});
`endif

        // Draw
        ngame(3);
        chk("ng_clear", {b1_3, b2_3, c3, t3, go3}, 32'd0);
        play(3, 1, 1'b1, 1'b0, 2'b00);
        play(3, 2, 1'b1, 1'b0, 2'b00);
        play(3, 3, 1'b1, 1'b0, 2'b00);
        play(3, 5, 1'b1, 1'b0, 2'b00);
        play(3, 4, 1'b1, 1'b0, 2'b00);
        play(3, 6, 1'b1, 1'b0, 2'b00);
        play(3, 8, 1'b1, 1'b0, 2'b00);
        play(3, 7, 1'b1, 1'b0, 2'b00);
        play(3, 9, 1'b1, 1'b1, 2'b00);
        drain();
        chk("draw_boards", {b1_3, b2_3}, {9'h18D, 9'h072});
        chk("draw_result", {w3, go3, c3, rdy3}, {2'b00, 1'b1, 4'd9, 1'b0});

        // new_game during CHECK aborts the move
        ngame(3);
        play(3, 1, 1'b1, 1'b0, 2'b00);
        drain();
        wait_ready(3);
        @(negedge clk);
        pv3 = 1'b1; pos3 = 4'd5;
        @(posedge clk); #1;
        pv3 = 1'b0;
        ng3 = 1'b1;
        @(posedge clk); #1;
        ng3 = 1'b0;
        mreset(0);
        chk("ng_check_next", {b1_3, b2_3, t3, rdy3, c3}, {9'h000, 9'h000, 1'b0, 1'b1, 4'd0});
        repeat (6) @(posedge clk);
        #1;
        chk("ng_check_later", {b1_3, b2_3, md3}, 32'd0);

        // reset during COMMIT leaves no board write
        wait_ready(3);
        @(negedge clk);
        pv3 = 1'b1; pos3 = 4'd9;
        @(posedge clk); #1;
        pv3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mreset(0); mreset(1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_commit", {b1_3, b2_3, c3, rdy3}, {9'h000, 9'h000, 4'd0, 1'b1});

        // 4x4 diagonal
        play(4, 1, 1'b1, 1'b0, 2'b00);
        play(4, 2, 1'b1, 1'b0, 2'b00);
        play(4, 6, 1'b1, 1'b0, 2'b00);
        play(4, 3, 1'b1, 1'b0, 2'b00);
        play(4, 11, 1'b1, 1'b0, 2'b00);
        play(4, 4, 1'b1, 1'b0, 2'b00);
`ifdef WIN_DETECT_EN
        play(4, 16, 1'b1, 1'b1, 2'b01);
        drain();
        chk("diag4", {b1_4, w4, go4, c4}, {16'h8421, 2'b01, 1'b1, 5'd7});
`else
        play(4, 16, 1'b1, 1'b0, 2'b00);
        drain();
        chk("diag4", {b1_4, w4, go4, c4}, {16'h8421, 2'b00, 1'b0, 5'd7});
`endif
        chk("queues_empty", 32'(q3.size() + q4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
